avalon_move_mailbox: RTL and testbench

- Parametrised Avalon-MM slave mailbox between the HPS software and the chess move engine.
- Software writes N argument words and a start bit. The engine streams result moves into an on-chip FIFO, and software pops them one per read.
- Provides a start/done handshake, FIFO status and sticky error flags.
- Supports multi-move results instead of a single result word.

---
 rtl/avalon_move_mailbox.sv | 144 ++++++++++++++
 tb/tb_avalon_move_mailbox.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_move_mailbox.sv
// Avalon-MM mailbox between HPS software and the move engine:
// argument registers, start/done handshake and a result-move FIFO.
module avalon_move_mailbox #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int NUM_ARG    = 8,
  parameter int MOVE_WIDTH = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_WIDTH-1:0]         slave_address,
  input  logic                          slave_read,
  input  logic                          slave_write,
  input  logic [DATA_WIDTH-1:0]         slave_writedata,
  input  logic [DATA_WIDTH/8-1:0]       slave_byteenable,
  output logic [DATA_WIDTH-1:0]         slave_readdata,
  output logic                          eng_start,
  output logic [NUM_ARG*DATA_WIDTH-1:0] eng_args,
  input  logic                          eng_move_valid,
  input  logic [MOVE_WIDTH-1:0]         eng_move_data,
  output logic                          eng_move_ready,
  input  logic                          eng_done
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (NUM_ARG > 1) ? $clog2(NUM_ARG) : 1;

  logic                  start;
  logic                  done;
  logic                  stall;
  logic                  underflow;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [15:0]           runcnt;
  logic [DATA_WIDTH-1:0] args [NUM_ARG];
  logic [MOVE_WIDTH-1:0] mem  [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] arg_off;
  logic [IW-1:0]         arg_idx;
  logic sel_ctrl, sel_sts, sel_pop, sel_run, sel_arg;
  logic ctrl_wr, sts_wr, arg_wr;
  logic clear, rise, stop;
  logic empty, full, push, pop, pop_empty;
  logic [DATA_WIDTH-1:0] rd_val;

  assign arg_off  = slave_address - ADDR_WIDTH'(4);
  assign arg_idx  = arg_off[IW-1:0];
  assign sel_ctrl = slave_address == ADDR_WIDTH'(0);
  assign sel_sts  = slave_address == ADDR_WIDTH'(1);
  assign sel_pop  = slave_address == ADDR_WIDTH'(2);
  assign sel_run  = slave_address == ADDR_WIDTH'(3);
  assign sel_arg  = (slave_address >= ADDR_WIDTH'(4)) &&
                    (arg_off < ADDR_WIDTH'(NUM_ARG));

  assign ctrl_wr = slave_write && sel_ctrl && slave_byteenable[0];
  assign sts_wr  = slave_write && sel_sts && slave_byteenable[2];
  assign arg_wr  = slave_write && sel_arg;
  assign clear   = ctrl_wr && slave_writedata[2];
  assign rise    = ctrl_wr && slave_writedata[0] && !start;
  assign stop    = ctrl_wr && !slave_writedata[0];

  assign empty          = count == '0;
  assign full           = count == CW'(FIFO_DEPTH);
  assign eng_move_ready = !full && !clear;
  assign push           = eng_move_valid && eng_move_ready;
  assign pop            = slave_read && sel_pop && !empty;
  assign pop_empty      = slave_read && sel_pop && empty;
  assign eng_start      = start;

  for (genvar g = 0; g < NUM_ARG; g++) begin : g_args
    assign eng_args[g*DATA_WIDTH +: DATA_WIDTH] = args[g];
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_ctrl: rd_val[1:0] = {done, start};
      sel_sts:  rd_val[19:0] = {underflow, stall, full, empty,
                                16'(count)};
      sel_pop:  if (!empty) rd_val[MOVE_WIDTH-1:0] = mem[rd_ptr];
      sel_run:  rd_val[15:0] = runcnt;
      sel_arg:  rd_val = args[arg_idx];
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= eng_move_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      start          <= 1'b0;
      done           <= 1'b0;
      stall          <= 1'b0;
      underflow      <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      runcnt         <= '0;
      slave_readdata <= '0;
      for (int i = 0; i < NUM_ARG; i++) args[i] <= '0;
    end else begin
      if (slave_read) slave_readdata <= rd_val;
      if (ctrl_wr) start <= slave_writedata[0];

      if (clear || rise || stop)    done <= 1'b0;
      else if (eng_done && start)   done <= 1'b1;

      // a new event wins over a same-cycle clear or W1C
      stall <= (stall && !clear && !(sts_wr && slave_writedata[18])) ||
               (eng_move_valid && !eng_move_ready);
      underflow <= (underflow && !clear &&
                    !(sts_wr && slave_writedata[19])) || pop_empty;

      if (clear || rise)                   runcnt <= '0;
      else if (push && runcnt != 16'hFFFF) runcnt <= runcnt + 16'd1;

      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end

      for (int i = 0; i < NUM_ARG; i++)
        for (int b = 0; b < BW; b++)
          if (arg_wr && arg_idx == IW'(i) && slave_byteenable[b])
            args[i][b*8 +: 8] <= slave_writedata[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_avalon_move_mailbox.sv
// Bench for avalon_move_mailbox: directed table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_avalon_move_mailbox;

  logic         clk;
  logic         reset;
  logic [14:0]  slave_address;
  logic         slave_read;
  logic         slave_write;
  logic [31:0]  slave_writedata;
  logic [3:0]   slave_byteenable;
  logic [31:0]  slave_readdata;
  logic         eng_start;
  logic [255:0] eng_args;
  logic         eng_move_valid;
  logic [11:0]  eng_move_data;
  logic         eng_move_ready;
  logic         eng_done;

  int nvec = 0;
  int nerr = 0;

  avalon_move_mailbox dut (
    .clk(clk), .reset(reset),
    .slave_address(slave_address), .slave_read(slave_read),
    .slave_write(slave_write), .slave_writedata(slave_writedata),
    .slave_byteenable(slave_byteenable),
    .slave_readdata(slave_readdata),
    .eng_start(eng_start), .eng_args(eng_args),
    .eng_move_valid(eng_move_valid), .eng_move_data(eng_move_data),
    .eng_move_ready(eng_move_ready), .eng_done(eng_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [14:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        v;
    logic [11:0] md;
    logic        dn;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  logic [11:0] mq[$];
  bit          m_start, m_done, m_stall, m_uf;
  int          m_rc;
  logic [31:0] m_args [8];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr,
      input logic [14:0] a, input logic [31:0] wd, input logic [3:0] be,
      input logic v, input logic [11:0] md, input logic dn,
      input logic c, input logic [31:0] e, input string n);
    vec_t t;
    t.rd = rd; t.wr = wr; t.a = a; t.wd = wd; t.be = be;
    t.v = v; t.md = md; t.dn = dn; t.chk = c; t.exp = e; t.name = n;
    return t;
  endfunction

  function automatic vec_t R(input logic [14:0] a, input logic [31:0] e,
                             input string n);
    return mk(1, 0, a, 0, 0, 0, 0, 0, 1, e, n);
  endfunction

  function automatic vec_t W(input logic [14:0] a, input logic [31:0] d,
                             input logic [3:0] be);
    return mk(0, 1, a, d, be, 0, 0, 0, 0, 0, "");
  endfunction

  function automatic vec_t P(input logic [11:0] md, input logic dn);
    return mk(0, 0, 0, 0, 0, 1, md, dn, 0, 0, "");
  endfunction

  task automatic idle();
    slave_read = 0; slave_write = 0; slave_address = 0;
    slave_writedata = 0; slave_byteenable = 0;
    eng_move_valid = 0; eng_move_data = 0; eng_done = 0;
  endtask

  task automatic step(input vec_t t);
    slave_read = t.rd; slave_write = t.wr; slave_address = t.a;
    slave_writedata = t.wd; slave_byteenable = t.be;
    eng_move_valid = t.v; eng_move_data = t.md; eng_done = t.dn;
    @(posedge clk); #1;
    idle();
    if (t.chk) chk(t.name, slave_readdata, t.exp);
  endtask

  function automatic logic [31:0] mread(input logic [14:0] a);
    int n;
    n = mq.size();
    if (a == 0) return {30'd0, m_done, m_start};
    if (a == 1) return {12'd0, m_uf, m_stall, n == 16, n == 0, 16'(n)};
    if (a == 2) return (n > 0) ? {20'd0, mq[0]} : 32'd0;
    if (a == 3) return {16'd0, 16'(m_rc)};
    if (a >= 4 && a < 12) return m_args[a-4];
    return 32'd0;
  endfunction

  initial begin
    idle();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    #1;
    chk("rst_ready", {31'd0, eng_move_ready}, 1);
    chk("rst_start", {31'd0, eng_start}, 0);
    chk("rst_args", {31'd0, |eng_args}, 0);

    tbl.push_back(R(1, 32'h0001_0000, "rst_status"));
    tbl.push_back(R(0, 32'h0, "rst_ctrl"));
    tbl.push_back(W(7, 32'hAAAA_AAAA, 4'hF));
    tbl.push_back(W(4, 32'h0000_1234, 4'hF));
    tbl.push_back(W(7, 32'h0000_00FF, 4'b0001));
    tbl.push_back(R(4, 32'h0000_1234, "arg0"));
    tbl.push_back(R(7, 32'hAAAA_AAFF, "arg3_be"));
    tbl.push_back(W(0, 32'h1, 4'hF));
    tbl.push_back(P(12'h040, 0));
    tbl.push_back(P(12'h081, 0));
    tbl.push_back(P(12'h0C2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ""));
    tbl.push_back(R(0, 32'h3, "ctrl_done"));
    tbl.push_back(R(3, 32'h3, "runcnt3"));
    tbl.push_back(R(1, 32'h0000_0003, "status3"));
    tbl.push_back(R(2, 32'h040, "pop0"));
    tbl.push_back(R(2, 32'h081, "pop1"));
    tbl.push_back(R(2, 32'h0C2, "pop2"));
    tbl.push_back(R(1, 32'h0001_0000, "status_empty"));
    tbl.push_back(R(2, 32'h0, "pop_empty"));
    tbl.push_back(R(1, 32'h0009_0000, "underflow_set"));
    tbl.push_back(W(1, 32'h0008_0000, 4'hF));
    tbl.push_back(R(1, 32'h0001_0000, "underflow_w1c"));
    tbl.push_back(W(12, 32'hDEAD_BEEF, 4'hF));
    tbl.push_back(R(12, 32'h0, "unmapped"));
    tbl.push_back(mk(1, 1, 4, 32'h5555, 4'hF, 0, 0, 0, 1, 32'h1234,
                     "rw_same_cycle"));
    tbl.push_back(R(4, 32'h5555, "arg0_new"));

    foreach (tbl[i]) step(tbl[i]);
    chk("eng_args_w0", eng_args[31:0], 32'h5555);
    chk("eng_args_w3", eng_args[127:96], 32'hAAAA_AAFF);
    chk("eng_start1", {31'd0, eng_start}, 1);

    // fill FIFO to full, then hold a 17th move against backpressure
    for (int i = 0; i < 16; i++) step(P(12'h100 + 12'(i), 0));
    eng_move_valid = 1; eng_move_data = 12'h110;
    #1;
    chk("full_ready", {31'd0, eng_move_ready}, 0);
    @(posedge clk); #1;
    slave_read = 1; slave_address = 1;
    @(posedge clk); #1;
    slave_read = 0;
    chk("full_status", slave_readdata, 32'h0006_0010);
    slave_read = 1; slave_address = 2;
    #1;
    chk("pop_cycle_ready", {31'd0, eng_move_ready}, 0);
    @(posedge clk); #1;
    slave_read = 0;
    chk("pop_full_head", slave_readdata, 32'h100);
    chk("ready_after_pop", {31'd0, eng_move_ready}, 1);
    @(posedge clk); #1;
    eng_move_valid = 0;
    step(R(1, 32'h0006_0010, "refull_status"));
    step(W(1, 32'h0004_0000, 4'hF));
    step(R(1, 32'h0002_0010, "stall_w1c"));
    step(R(3, 32'd20, "runcnt20"));
    for (int i = 1; i < 12; i++)
      step(R(2, 32'h100 + i, "pop_order"));

    // clear with 5 queued and a push in the same cycle
    slave_write = 1; slave_address = 0;
    slave_writedata = 32'h5; slave_byteenable = 4'hF;
    eng_move_valid = 1; eng_move_data = 12'h777;
    #1;
    chk("clear_ready", {31'd0, eng_move_ready}, 0);
    @(posedge clk); #1;
    idle();
    step(R(1, 32'h0005_0000, "clear_status"));
    step(R(0, 32'h1, "clear_ctrl"));
    step(R(3, 32'h0, "clear_runcnt"));
    step(W(1, 32'h0004_0000, 4'hF));

    // start/done handshake corners
    step(W(0, 32'h0, 4'hF));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ""));
    step(R(0, 32'h0, "done_ignored"));
    step(W(0, 32'h1, 4'hF));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ""));
    step(W(0, 32'h1, 4'hF));
    step(R(0, 32'h3, "restart_noeffect"));
    step(W(0, 32'h0, 4'hF));
    step(R(0, 32'h0, "stop_clears_done"));
    step(W(0, 32'h1, 4'hF));
    step(P(12'h2AB, 1));
    step(R(0, 32'h3, "push_done_ctrl"));
    step(R(1, 32'h0000_0001, "push_done_count"));
    step(R(3, 32'h1, "push_done_runcnt"));

    // reset in the middle of a push burst
    step(P(12'h031, 0));
    step(P(12'h032, 0));
    eng_move_valid = 1; eng_move_data = 12'h03C;
    reset = 0;
    @(posedge clk); #1;
    chk("rst_mid_start", {31'd0, eng_start}, 0);
    reset = 1;
    eng_move_valid = 0;
    #1;
    chk("rst_mid_ready", {31'd0, eng_move_ready}, 1);
    chk("rst_mid_args", {31'd0, |eng_args}, 0);
    step(R(1, 32'h0001_0000, "rst_mid_status"));
    step(R(0, 32'h0, "rst_mid_ctrl"));
    step(R(3, 32'h0, "rst_mid_runcnt"));

    // randomized traffic, model starts from the reset state
    mq.delete();
    m_start = 0; m_done = 0; m_stall = 0; m_uf = 0; m_rc = 0;
    foreach (m_args[i]) m_args[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      automatic logic rd, wr, v, dn, clr, rdy, rise, ctw;
      automatic logic [14:0] a = 0;
      automatic logic [31:0] wd = 0;
      automatic logic [31:0] er;
      automatic logic [3:0] be = 0;
      automatic logic [11:0] md;
      automatic int k = $urandom_range(0, 9);
      rd = k < 4;
      wr = (k == 4) || (k == 5);
      if (rd) a = ($urandom_range(0, 2) == 0) ? 15'd2
                                              : 15'($urandom_range(0, 15));
      if (wr) begin
        be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        wd = $urandom;
        case ($urandom_range(0, 3))
          0: begin
            a = 0;
            wd[2] = $urandom_range(0, 7) == 0;
            wd[0] = $urandom_range(0, 2) != 0;
          end
          1: a = 1;
          2: a = 15'(4 + $urandom_range(0, 7));
          default: a = 15'(12 + $urandom_range(0, 100));
        endcase
        rd = $urandom_range(0, 3) == 0;
      end
      v  = !wr && ($urandom_range(0, 2) != 0);
      dn = !wr && ($urandom_range(0, 15) == 0);
      md = 12'($urandom);
      er = mread(a);
      ctw  = wr && a == 0 && be[0];
      clr  = ctw && wd[2];
      rise = ctw && wd[0] && !m_start;
      rdy  = (mq.size() < 16) && !clr;

      slave_read = rd; slave_write = wr; slave_address = a;
      slave_writedata = wd; slave_byteenable = be;
      eng_move_valid = v; eng_move_data = md; eng_done = dn;
      #1;
      chk("rnd_ready", {31'd0, eng_move_ready}, {31'd0, rdy});
      @(posedge clk); #1;
      idle();
      if (rd) chk("rnd_read", slave_readdata, er);

      if (wr && a == 1 && be[2]) begin
        if (wd[18]) m_stall = 0;
        if (wd[19]) m_uf = 0;
      end
      if (rd && a == 2 && mq.size() == 0) m_uf = 1;
      if (v && !rdy) m_stall = 1;
      if (ctw && (clr || rise || !wd[0])) m_done = 0;
      else if (dn && m_start) m_done = 1;
      if (ctw) m_start = wd[0];
      if (clr || rise) m_rc = 0;
      else if (v && rdy && m_rc < 65535) m_rc++;
      if (clr) begin
        mq.delete();
        m_stall = v;
        m_uf = 0;
      end else begin
        if (rd && a == 2 && mq.size() > 0) void'(mq.pop_front());
        if (v && rdy) mq.push_back(md);
      end
      if (wr && a >= 4 && a < 12)
        for (int b = 0; b < 4; b++)
          if (be[b]) m_args[a-4][b*8 +: 8] = wd[b*8 +: 8];

      chk("rnd_start", {31'd0, eng_start}, {31'd0, m_start});
      if (c % 100 == 99)
        for (int i = 0; i < 8; i++)
          chk("rnd_args", eng_args[i*32 +: 32], m_args[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
